ascon_job_arbiter: RTL
======================

// Module: ascon_job_arbiter
// PURPOSE
//  Sequences and shares the single PUF-keyed Ascon engine between the encrypt and decrypt requesters
//  driven by the secure-config JTAG register. Fetches the PUF key on demand, arbitrates round-robin,
//  issues one-cycle core start pulses and supervises each job with timeouts. Sits between the
//  secure-config register and the Ascon core, all on the TCK domain.
// PARAMETERS
//  PUF_TIMEOUT   64  max cycles in KEY_WAIT before error (>=2)
//  CORE_TIMEOUT  256 max cycles in BUSY before error (>=2)
//  REFRESH_JOBS  16  successful jobs per key when KEY_REFRESH_EN is defined (>=1)
// PORTS
//  clk            in  1  TCK
//  rst_n          in  1  async active-low reset (TRST_N)
//  enc_req        in  1  encrypt request, level
//  dec_req        in  1  decrypt request, level
//  enc_ack        out 1  1-cycle pulse: encrypt job finished
//  dec_ack        out 1  1-cycle pulse: decrypt job finished
//  job_err        out 1  valid with ack: 1 = job aborted (timeout)
//  cfg_challenge  in  5  PUF challenge, sampled in KEY_REQ
//  key_flush      in  1  pulse: invalidate held key
//  puf_generate   out 1  1-cycle pulse to PUF
//  puf_challenge  out 5  challenge to PUF, held from KEY_REQ until KEY_WAIT exits
//  puf_ready      in  1  PUF response valid
//  puf_response   in  16 PUF key material
//  key_out        out 16 latched key to Ascon core
//  key_valid      out 1  key_out usable
//  core_start     out 1  1-cycle start pulse to Ascon core
//  core_mode      out 1  0 = encrypt, 1 = decrypt; stable from START until DONE/ERR
//  core_done      in  1  Ascon job complete
//  busy           out 1  state != IDLE
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, state IDLE, last_grant=1, counters 0.
//    rst_n low mid-job aborts immediately with no ack.
//  - FSM: IDLE, KEY_REQ, KEY_WAIT, START, BUSY, DONE, ERR.
//  - IDLE: sample reqs. One req -> grant it. Both -> grant the one != last_grant (first tie
//    goes to enc). Latch core_mode. Go to START if key_valid, else KEY_REQ.
//  - KEY_REQ: puf_generate=1 for one cycle, puf_challenge<=cfg_challenge, clear timer -> KEY_WAIT.
//  - KEY_WAIT: on puf_ready, key_out<=puf_response, key_valid<=1 -> START. If timer reaches
//    PUF_TIMEOUT -> ERR.
//  - START: core_start=1 for one cycle, clear timer -> BUSY.
//  - BUSY: on core_done -> DONE. If timer reaches CORE_TIMEOUT -> ERR. core_done outside BUSY
//    is ignored.
//  - DONE: granted ack=1, job_err=0, last_grant<=granted -> IDLE.
//  - ERR: granted ack=1, job_err=1, key_valid<=0, key_out<=0 -> IDLE. last_grant updates.
//  - Latency with key valid: req seen at cycle 0, core_start at cycle 1, core_done at cycle n,
//    ack at n+1. A req still high in the cycle after ack starts a new job.
//    A req dropped before grant is lost.
//  - key_flush in IDLE clears key_valid next cycle. Mid-job it sets flush_pending; the flush is
//    applied on entry to IDLE, after the current job's ack.
//  - Timers are saturating, CORE_TIMEOUT-wide via $clog2, and never wrap.
// CONFIGURATION
//  KEY_REFRESH_EN defined:
//    - 8-bit job counter increments on each DONE.
//    - When it reaches REFRESH_JOBS it clears to 0 and key_valid<=0 on entry to IDLE, forcing a
//      PUF re-fetch on the next job.
//    - ERR and key_flush also clear the counter.
//  KEY_REFRESH_EN undefined:
//    - No counter. The key persists until key_flush, ERR or reset.
// TESTING
//  1. Reset, enc_req=1, cfg_challenge=5'h0A, puf_ready 3 cycles after generate with
//     response 16'hBEEF -> one puf_generate, puf_challenge=5'h0A, key_out=16'hBEEF,
//     core_start with mode 0, enc_ack=1 with job_err=0 one cycle after core_done.
//  2. Key valid, enc_req and dec_req both high -> enc first, then dec, then enc;
//     no second puf_generate.
//  3. puf_ready never asserted -> ERR after 64 KEY_WAIT cycles, ack with job_err=1,
//     key_valid=0, and no core_start.
//  4. core_done withheld -> ERR at 256 BUSY cycles, key_valid=0; the next req re-fetches the key.
//  5. key_flush during BUSY -> current job acks with err=0, key_valid=0 the cycle after ack,
//     and the next job issues puf_generate.
//  6. KEY_REFRESH_EN, REFRESH_JOBS=2 -> 3 back-to-back enc jobs give exactly 2 puf_generate
//     pulses. rst_n low mid-BUSY -> all outputs 0 and no ack.

Source files
------------

// File: rtl/ascon_job_arbiter_if.sv
// Handshake bundle between the Ascon job arbiter, its two requesters, the PUF and the Ascon core.
// The master modport is the arbiter side; the slave modport is the surrounding environment.
interface ascon_job_arbiter_if;
  logic        enc_req;
  logic        dec_req;
  logic        enc_ack;
  logic        dec_ack;
  logic        job_err;
  logic [4:0]  cfg_challenge;
  logic        key_flush;
  logic        puf_generate;
  logic [4:0]  puf_challenge;
  logic        puf_ready;
  logic [15:0] puf_response;
  logic [15:0] key_out;
  logic        key_valid;
  logic        core_start;
  logic        core_mode;
  logic        core_done;
  logic        busy;

  modport master (
    input  enc_req, dec_req, cfg_challenge, key_flush, puf_ready, puf_response, core_done,
    output enc_ack, dec_ack, job_err, puf_generate, puf_challenge, key_out, key_valid,
    output core_start, core_mode, busy
  );

  modport slave (
    output enc_req, dec_req, cfg_challenge, key_flush, puf_ready, puf_response, core_done,
    input  enc_ack, dec_ack, job_err, puf_generate, puf_challenge, key_out, key_valid,
    input  core_start, core_mode, busy
  );
endinterface

// File: rtl/ascon_job_arbiter.sv
// Round-robin job sequencer sharing one PUF-keyed Ascon core between encrypt and decrypt.
// Optional KEY_REFRESH_EN: drop the key after REFRESH_JOBS successful jobs to force a re-fetch.
module ascon_job_arbiter #(
  parameter int unsigned PUF_TIMEOUT  = 64,
  parameter int unsigned CORE_TIMEOUT = 256,
  parameter int unsigned REFRESH_JOBS = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  ascon_job_arbiter_if.master bus_io
);
  // Timer is sized for the larger timeout so neither limit can be unreachable.
  localparam int unsigned TmoMax = (PUF_TIMEOUT > CORE_TIMEOUT) ? PUF_TIMEOUT : CORE_TIMEOUT;
  localparam int unsigned TimerW = $clog2(TmoMax + 1);
  localparam logic [TimerW-1:0] PufLast  = TimerW'(PUF_TIMEOUT - 1);
  localparam logic [TimerW-1:0] CoreLast = TimerW'(CORE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StKeyReq, StKeyWait, StStart, StBusy, StDone, StErr
  } state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic                last_grant_q, last_grant_d;
  logic [TimerW-1:0]   timer_q, timer_d, timer_inc;
  logic                flush_pend_q, flush_pend_d;
  logic [15:0]         key_q, key_d;
  logic                key_valid_q, key_valid_d;
  logic [4:0]          puf_chal_q, puf_chal_d;
  logic                enc_ack_q, dec_ack_q, job_err_q, puf_gen_q, core_start_q, busy_q;
  logic                grant;
  logic                refresh_hit;

`ifdef KEY_REFRESH_EN
  localparam logic [7:0] RefreshJobs8 = 8'(REFRESH_JOBS);
  logic [7:0] job_cnt_q, job_cnt_d;

  always_comb begin
    job_cnt_d   = job_cnt_q;
    refresh_hit = 1'b0;
    if (state_q == StDone) begin
      if (job_cnt_q + 8'd1 >= RefreshJobs8) begin
        job_cnt_d   = '0;
        refresh_hit = 1'b1;
      end else begin
        job_cnt_d = job_cnt_q + 8'd1;
      end
    end
    if (state_q == StErr || bus_io.key_flush || flush_pend_q) job_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) job_cnt_q <= '0;
    else        job_cnt_q <= job_cnt_d;
  end
`else
  assign refresh_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    flush_pend_d = flush_pend_q;
    key_d        = key_q;
    key_valid_d  = key_valid_q;
    puf_chal_d   = puf_chal_q;
    grant        = 1'b0;
    timer_inc    = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    if (bus_io.key_flush && state_q != StIdle) flush_pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus_io.key_flush) key_valid_d = 1'b0;
        if (bus_io.enc_req || bus_io.dec_req) begin
          // 0 = encrypt, 1 = decrypt; on a tie the side not served last wins.
          grant   = (bus_io.enc_req && bus_io.dec_req) ? ~last_grant_q : bus_io.dec_req;
          mode_d  = grant;
          state_d = (key_valid_q && !bus_io.key_flush) ? StStart : StKeyReq;
        end
      end
      StKeyReq: begin
        timer_d = '0;
        state_d = StKeyWait;
      end
      StKeyWait: begin
        if (bus_io.puf_ready) begin
          key_d       = bus_io.puf_response;
          key_valid_d = 1'b1;
          state_d     = StStart;
        end else if (timer_q >= PufLast) begin
          state_d = StErr;
        end else begin
          timer_d = timer_inc;
        end
      end
      StStart: begin
        timer_d = '0;
        state_d = StBusy;
      end
      StBusy: begin
        if (bus_io.core_done)          state_d = StDone;
        else if (timer_q >= CoreLast)  state_d = StErr;
        else                           timer_d = timer_inc;
      end
      StDone: begin
        last_grant_d = mode_q;
        if (refresh_hit) key_valid_d = 1'b0;
        state_d = StIdle;
      end
      StErr: begin
        last_grant_d = mode_q;
        key_valid_d  = 1'b0;
        key_d        = '0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A flush seen mid-job lands only once the job has been acknowledged.
    if ((state_q == StDone || state_q == StErr) && (flush_pend_q || bus_io.key_flush)) begin
      key_valid_d  = 1'b0;
      flush_pend_d = 1'b0;
    end

    if (state_d == StKeyReq)       puf_chal_d = bus_io.cfg_challenge;
    else if (state_d != StKeyWait) puf_chal_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      puf_chal_q   <= '0;
      enc_ack_q    <= 1'b0;
      dec_ack_q    <= 1'b0;
      job_err_q    <= 1'b0;
      puf_gen_q    <= 1'b0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      flush_pend_q <= flush_pend_d;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
      puf_chal_q   <= puf_chal_d;
      enc_ack_q    <= (state_d == StDone || state_d == StErr) && !mode_d;
      dec_ack_q    <= (state_d == StDone || state_d == StErr) && mode_d;
      job_err_q    <= (state_d == StErr);
      puf_gen_q    <= (state_d == StKeyReq);
      core_start_q <= (state_d == StStart);
      busy_q       <= (state_d != StIdle);
    end
  end

  assign bus_io.enc_ack       = enc_ack_q;
  assign bus_io.dec_ack       = dec_ack_q;
  assign bus_io.job_err       = job_err_q;
  assign bus_io.puf_generate  = puf_gen_q;
  assign bus_io.puf_challenge = puf_chal_q;
  assign bus_io.key_out       = key_q;
  assign bus_io.key_valid     = key_valid_q;
  assign bus_io.core_start    = core_start_q;
  assign bus_io.core_mode     = mode_q;
  assign bus_io.busy          = busy_q;
endmodule
